rs422_test_sequencer: RTL and testbench

Autonomous sequencer that drives the RS422 loopback test register block over its OPB-style register port. It runs a configurable series of test patterns, each transmitting a fixed byte count. For each pattern it programs, clears, starts and polls the test block, then reads back all nine error counters. Results are accumulated into a per-channel fail mask and an error total, so software issues one start and reads one result instead of hand-sequencing dozens of register accesses.

---
 rtl/rs422_test_sequencer.sv | 240 ++++++++++++++++++++++++
 tb/tb_rs422_test_sequencer.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs422_test_sequencer.sv
// Autonomous RS422 loopback test sequencer: programs, starts and polls the test
// register block for a series of patterns and accumulates per-channel results.
module rs422_test_sequencer #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000,
  parameter logic [31:0] SETTLE_CYCLES  = 32'd17_400
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST,
  input  logic        SEQ_START,
  input  logic        SEQ_ABORT,
  input  logic [7:0]  SEQ_SEED,
  input  logic [7:0]  SEQ_STEP,
  input  logic [7:0]  SEQ_NUM_PAT,
  input  logic [31:0] SEQ_BYTES,
  output logic [7:0]  M_ADDR,
  output logic [31:0] M_WDATA,
  output logic        M_WE,
  output logic        M_RE,
  input  logic [31:0] M_RDATA,
  output logic        SEQ_BUSY,
  output logic        SEQ_DONE,
  output logic        SEQ_PASS,
  output logic [8:0]  SEQ_FAIL_MASK,
  output logic [31:0] SEQ_ERR_TOTAL,
  output logic [7:0]  SEQ_PAT_IDX,
  output logic        SEQ_TIMEOUT,
  output logic        SEQ_REJECT
);

  localparam logic [7:0]  ADDR_PAT  = 8'h00;
  localparam logic [7:0]  ADDR_CNT  = 8'h01;
  localparam logic [7:0]  ADDR_CTRL = 8'h02;
  localparam logic [7:0]  ADDR_STAT = 8'h03;
  localparam logic [7:0]  ADDR_ERR0 = 8'h0D;
  localparam logic [31:0] CTRL_GO   = 32'd1;
  localparam logic [31:0] CTRL_STOP = 32'd2;
  localparam logic [31:0] CTRL_CLR  = 32'd4;

  typedef enum logic [4:0] {
    S_IDLE, S_WR_PAT, S_WR_CNT, S_WR_CLR, S_GAP, S_WR_GO, S_POLL_RD, S_POLL_CHK,
    S_SETTLE, S_STAT_RD, S_STAT_CHK, S_ERR_RD, S_ERR_CHK, S_NEXT, S_WR_STOP,
    S_STOP_AB, S_FIN
  } state_t;

  state_t      r_state;
  logic [7:0]  r_addr;
  logic [31:0] r_wdata;
  logic        r_we, r_re;
  logic        r_busy, r_done, r_pass, r_tmo_flag, r_reject, r_aborted;
  logic [8:0]  r_mask;
  logic [31:0] r_total;
  logic [7:0]  r_idx, r_pat, r_step, r_num;
  logic [31:0] r_bytes;
  logic [31:0] r_cnt;
  logic [3:0]  r_j;

  logic        w_abort;
  logic        w_last;
  logic [32:0] w_sum;

  // An abort is only taken in a cycle with no access on the bus, so a strobe is never cut short.
  assign w_abort = SEQ_ABORT && (r_state != S_IDLE) && !(r_we || r_re);
  assign w_last  = (r_idx == (r_num - 8'd1));
  assign w_sum   = {1'b0, r_total} + {1'b0, M_RDATA};

  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_re       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_tmo_flag <= 1'b0;
      r_reject   <= 1'b0;
      r_aborted  <= 1'b0;
      r_mask     <= '0;
      r_total    <= '0;
      r_idx      <= '0;
      r_pat      <= '0;
      r_step     <= '0;
      r_num      <= '0;
      r_bytes    <= '0;
      r_cnt      <= '0;
      r_j        <= '0;
    end else begin
      // NOTE: strobes and pulses default low with <= so each is exactly one cycle wide;
      // later <= assignments in the same block override these defaults.
      r_we     <= 1'b0;
      r_re     <= 1'b0;
      r_done   <= 1'b0;
      r_reject <= 1'b0;
      if (w_abort) begin
        r_aborted <= 1'b1;
        r_we      <= 1'b1;
        r_addr    <= ADDR_CTRL;
        r_wdata   <= CTRL_STOP;
        r_state   <= S_STOP_AB;
      end else begin
        case (r_state)
          S_IDLE: if (SEQ_START) begin
            if (SEQ_BYTES == 32'd0) begin
              r_reject <= 1'b1;
            end else begin
              r_pat      <= SEQ_SEED;
              r_step     <= SEQ_STEP;
              r_num      <= SEQ_NUM_PAT;
              r_bytes    <= SEQ_BYTES;
              r_mask     <= '0;
              r_total    <= '0;
              r_tmo_flag <= 1'b0;
              r_idx      <= '0;
              r_aborted  <= 1'b0;
              r_pass     <= 1'b0;
              r_busy     <= 1'b1;
              r_we       <= 1'b1;
              r_addr     <= ADDR_PAT;
              r_wdata    <= {24'd0, SEQ_SEED};
              r_state    <= S_WR_PAT;
            end
          end
          S_WR_PAT: begin
            r_we <= 1'b1; r_addr <= ADDR_CNT; r_wdata <= r_bytes;
            r_state <= S_WR_CNT;
          end
          S_WR_CNT: begin
            r_we <= 1'b1; r_addr <= ADDR_CTRL; r_wdata <= CTRL_CLR;
            r_state <= S_WR_CLR;
          end
          S_WR_CLR: begin
            r_cnt   <= 32'd1;
            r_state <= S_GAP;
          end
          S_GAP: begin
            if (r_cnt == 32'd0) begin
              r_we <= 1'b1; r_addr <= ADDR_CTRL; r_wdata <= CTRL_GO;
              r_state <= S_WR_GO;
            end else begin
              r_cnt <= r_cnt - 32'd1;
            end
          end
          S_WR_GO: begin
            r_cnt <= TIMEOUT_CYCLES;
            r_re  <= 1'b1; r_addr <= ADDR_STAT;
            r_state <= S_POLL_RD;
          end
          S_POLL_RD: begin
            if (r_cnt != 32'd0) r_cnt <= r_cnt - 32'd1;
            r_state <= S_POLL_CHK;
          end
          S_POLL_CHK: begin
            if (M_RDATA[0]) begin
              r_cnt   <= SETTLE_CYCLES;
              r_state <= S_SETTLE;
            end else if (r_cnt == 32'd0) begin
              r_we <= 1'b1; r_addr <= ADDR_CTRL; r_wdata <= CTRL_STOP;
              r_state <= S_WR_STOP;
            end else begin
              r_cnt <= r_cnt - 32'd1;
              r_re  <= 1'b1; r_addr <= ADDR_STAT;
              r_state <= S_POLL_RD;
            end
          end
          S_SETTLE: begin
            if (r_cnt <= 32'd1) begin
              r_re <= 1'b1; r_addr <= ADDR_STAT;
              r_state <= S_STAT_RD;
            end else begin
              r_cnt <= r_cnt - 32'd1;
            end
          end
          S_STAT_RD: r_state <= S_STAT_CHK;
          S_STAT_CHK: begin
            r_mask <= r_mask | ~M_RDATA[9:1];
            r_j    <= '0;
            r_re   <= 1'b1; r_addr <= ADDR_ERR0;
            r_state <= S_ERR_RD;
          end
          S_ERR_RD: r_state <= S_ERR_CHK;
          S_ERR_CHK: begin
            r_total <= w_sum[32] ? 32'hFFFF_FFFF : w_sum[31:0];
            if (M_RDATA != 32'd0) r_mask[r_j] <= 1'b1;
            if (r_j == 4'd8) begin
              r_state <= S_NEXT;
            end else begin
              r_j  <= r_j + 4'd1;
              r_re <= 1'b1; r_addr <= ADDR_ERR0 + {4'd0, r_j} + 8'd1;
              r_state <= S_ERR_RD;
            end
          end
          S_NEXT: begin
            if (w_last) begin
              r_we <= 1'b1; r_addr <= ADDR_CTRL; r_wdata <= CTRL_CLR;
              r_state <= S_FIN;
            end else begin
              r_idx   <= r_idx + 8'd1;
              r_pat   <= r_pat + r_step;
              r_we    <= 1'b1; r_addr <= ADDR_PAT; r_wdata <= {24'd0, r_pat + r_step};
              r_state <= S_WR_PAT;
            end
          end
          S_WR_STOP: begin
            r_tmo_flag <= 1'b1;
            r_mask     <= 9'h1FF;
            r_j        <= '0;
            r_re       <= 1'b1; r_addr <= ADDR_ERR0;
            r_state    <= S_ERR_RD;
          end
          S_STOP_AB: begin
            r_we <= 1'b1; r_addr <= ADDR_CTRL; r_wdata <= CTRL_CLR;
            r_state <= S_FIN;
          end
          S_FIN: begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_pass  <= (r_mask == 9'd0) && !r_tmo_flag && !r_aborted;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign M_ADDR        = r_addr;
  assign M_WDATA       = r_wdata;
  assign M_WE          = r_we;
  assign M_RE          = r_re;
  assign SEQ_BUSY      = r_busy;
  assign SEQ_DONE      = r_done;
  assign SEQ_PASS      = r_pass;
  assign SEQ_FAIL_MASK = r_mask;
  assign SEQ_ERR_TOTAL = r_total;
  assign SEQ_PAT_IDX   = r_idx;
  assign SEQ_TIMEOUT   = r_tmo_flag;
  assign SEQ_REJECT    = r_reject;

endmodule

// File: tb/tb_rs422_test_sequencer.sv
// Directed bench for rs422_test_sequencer with a behavioural model of the RS422
// loopback test register block and a bus monitor.
module tb_rs422_test_sequencer;

  localparam int MODEL_RUN = 20;

  logic        clk;
  logic        rst;
  logic        SEQ_START, SEQ_ABORT;
  logic [7:0]  SEQ_SEED, SEQ_STEP, SEQ_NUM_PAT;
  logic [31:0] SEQ_BYTES;
  logic [7:0]  M_ADDR;
  logic [31:0] M_WDATA;
  logic        M_WE, M_RE;
  logic [31:0] M_RDATA;
  logic        SEQ_BUSY, SEQ_DONE, SEQ_PASS, SEQ_TIMEOUT, SEQ_REJECT;
  logic [8:0]  SEQ_FAIL_MASK;
  logic [31:0] SEQ_ERR_TOTAL;
  logic [7:0]  SEQ_PAT_IDX;

  int checks = 0;
  int errors = 0;

  rs422_test_sequencer #(.TIMEOUT_CYCLES(32'd100), .SETTLE_CYCLES(32'd10)) dut (
    .OPB_CLK(clk), .OPB_RST(rst), .SEQ_START(SEQ_START), .SEQ_ABORT(SEQ_ABORT),
    .SEQ_SEED(SEQ_SEED), .SEQ_STEP(SEQ_STEP), .SEQ_NUM_PAT(SEQ_NUM_PAT), .SEQ_BYTES(SEQ_BYTES),
    .M_ADDR(M_ADDR), .M_WDATA(M_WDATA), .M_WE(M_WE), .M_RE(M_RE), .M_RDATA(M_RDATA),
    .SEQ_BUSY(SEQ_BUSY), .SEQ_DONE(SEQ_DONE), .SEQ_PASS(SEQ_PASS), .SEQ_FAIL_MASK(SEQ_FAIL_MASK),
    .SEQ_ERR_TOTAL(SEQ_ERR_TOTAL), .SEQ_PAT_IDX(SEQ_PAT_IDX), .SEQ_TIMEOUT(SEQ_TIMEOUT),
    .SEQ_REJECT(SEQ_REJECT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Test block model: one channel (fault_ch, 1..9) may receive constant 0xFF.
  int          fault_ch = 0;
  logic        hang = 1'b0;
  logic [7:0]  m_pat;
  logic [31:0] m_cnt;
  logic [9:0]  m_status;
  logic        m_running;
  int          m_run_cnt;
  logic [31:0] rdata_q;
  assign M_RDATA = rdata_q;

  function automatic logic [8:0] ok_bits();
    logic [8:0] ok = 9'h1FF;
    if (fault_ch != 0) ok[fault_ch-1] = 1'b0;
    return ok;
  endfunction

  function automatic logic [31:0] err_of(input int ch);
    if (ch == fault_ch && m_pat != 8'hFF) return m_cnt;
    return 32'd0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pat <= '0; m_cnt <= '0; m_status <= '0; m_running <= 1'b0; m_run_cnt <= 0; rdata_q <= '0;
    end else begin
      if (m_running && !hang) begin
        if (m_run_cnt == 0) begin
          m_status  <= {ok_bits(), 1'b1};
          m_running <= 1'b0;
        end else begin
          m_run_cnt <= m_run_cnt - 1;
        end
      end
      if (M_WE) begin
        case (M_ADDR)
          8'h00: m_pat <= M_WDATA[7:0];
          8'h01: m_cnt <= M_WDATA;
          8'h02: begin
            if (M_WDATA[2]) begin m_status <= '0; m_running <= 1'b0; end
            if (M_WDATA[1]) m_running <= 1'b0;
            if (M_WDATA[0]) begin m_running <= 1'b1; m_run_cnt <= MODEL_RUN; end
          end
          default: ;
        endcase
      end
      if (M_RE) begin
        if (M_ADDR == 8'h03) rdata_q <= {22'd0, m_status};
        else if (M_ADDR >= 8'h0D && M_ADDR <= 8'h15) rdata_q <= err_of(int'(M_ADDR) - 12);
        else rdata_q <= 32'd0;
      end
    end
  end

  // Bus monitor, sampled on the falling edge.
  typedef struct { logic [7:0] a; logic [31:0] d; int c; } wr_t;
  wr_t        wq[$];
  logic [7:0] rq[$];
  int         cyc = 0;
  int         done_cnt = 0;
  int         reject_cnt = 0;
  logic       both_seen = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (M_WE) wq.push_back('{M_ADDR, M_WDATA, cyc});
    if (M_RE) rq.push_back(M_ADDR);
    if (M_WE && M_RE) both_seen = 1'b1;
    if (SEQ_DONE) done_cnt++;
    if (SEQ_REJECT) reject_cnt++;
  end

  task automatic start_run(input logic [7:0] seed, input logic [7:0] step,
                           input logic [7:0] num, input logic [31:0] bytes, input logic abort);
    @(negedge clk);
    SEQ_SEED = seed; SEQ_STEP = step; SEQ_NUM_PAT = num; SEQ_BYTES = bytes;
    SEQ_START = 1'b1; SEQ_ABORT = abort;
    @(negedge clk);
    SEQ_START = 1'b0; SEQ_ABORT = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (SEQ_DONE) begin found = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({M_ADDR, M_WDATA, M_WE, M_RE} !== 42'd0) begin
      errors++; $display("FAIL reset_bus: got %h expected 0", {M_ADDR, M_WDATA, M_WE, M_RE});
    end
    checks++;
    if ({SEQ_BUSY, SEQ_DONE, SEQ_PASS, SEQ_FAIL_MASK, SEQ_ERR_TOTAL, SEQ_PAT_IDX, SEQ_TIMEOUT, SEQ_REJECT} !== 54'd0) begin
      errors++; $display("FAIL reset_status: got %h expected 0",
        {SEQ_BUSY, SEQ_DONE, SEQ_PASS, SEQ_FAIL_MASK, SEQ_ERR_TOTAL, SEQ_PAT_IDX, SEQ_TIMEOUT, SEQ_REJECT});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_good;
    wr_t        exp_w[5];
    int         wb, rb, db, n3;
    bit         found;
    exp_w = '{'{8'h00, 32'h55, 0}, '{8'h01, 32'd4, 0}, '{8'h02, 32'd4, 0},
              '{8'h02, 32'd1, 0}, '{8'h02, 32'd4, 0}};
    fault_ch = 0; hang = 1'b0;
    wb = wq.size(); rb = rq.size(); db = done_cnt;
    start_run(8'h55, 8'h00, 8'd1, 32'd4, 1'b0);
    checks++;
    if ({SEQ_BUSY, M_WE, M_ADDR, M_WDATA} !== {1'b1, 1'b1, 8'h00, 32'h55}) begin
      errors++; $display("FAIL good_first_write: got busy/we/addr/data %h expected %h",
        {SEQ_BUSY, M_WE, M_ADDR, M_WDATA}, {1'b1, 1'b1, 8'h00, 32'h55});
    end
    wait_done(2000, found);
    checks++;
    if (!found) begin errors++; $display("FAIL good_done: got no SEQ_DONE expected pulse"); end
    checks++;
    if ({SEQ_PASS, SEQ_FAIL_MASK, SEQ_ERR_TOTAL, SEQ_TIMEOUT} !== {1'b1, 9'h000, 32'd0, 1'b0}) begin
      errors++; $display("FAIL good_result: got pass/mask/total/tmo %h expected %h",
        {SEQ_PASS, SEQ_FAIL_MASK, SEQ_ERR_TOTAL, SEQ_TIMEOUT}, {1'b1, 9'h000, 32'd0, 1'b0});
    end
    repeat (4) @(negedge clk);
    checks++;
    if (done_cnt - db !== 1 || SEQ_BUSY !== 1'b0) begin
      errors++; $display("FAIL good_done_count: got %0d pulses busy=%b expected 1 pulses busy=0", done_cnt - db, SEQ_BUSY);
    end
    checks++;
    if (wq.size() - wb !== 5) begin
      errors++; $display("FAIL good_write_count: got %0d expected 5", wq.size() - wb);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (wq[wb+i].a !== exp_w[i].a || wq[wb+i].d !== exp_w[i].d) begin
          errors++; $display("FAIL good_write%0d: got %h/%h expected %h/%h", i,
            wq[wb+i].a, wq[wb+i].d, exp_w[i].a, exp_w[i].d);
        end
      end
    end
    n3 = 0;
    for (int i = rb; i < rq.size(); i++) if (rq[i] == 8'h03) n3++;
    checks++;
    if (rq.size() - rb < 11 || n3 < 2) begin
      errors++; $display("FAIL good_reads: got %0d reads (%0d status) expected >=11 (>=2 status)", rq.size() - rb, n3);
    end else begin
      for (int j = 0; j < 9; j++) begin
        logic [7:0] ea;
        ea = 8'h0D + 8'(j);
        checks++;
        if (rq[rq.size()-9+j] !== ea) begin
          errors++; $display("FAIL good_err_read%0d: got %h expected %h", j, rq[rq.size()-9+j], ea);
        end
      end
    end
  endtask

  task automatic test_stuck_rx3;
    logic [7:0] exp_p[3];
    logic [7:0] got_p[$];
    int         wb;
    bit         found;
    exp_p = '{8'h00, 8'h55, 8'hAA};
    fault_ch = 3; hang = 1'b0;
    wb = wq.size();
    start_run(8'h00, 8'h55, 8'd3, 32'd4, 1'b0);
    wait_done(5000, found);
    checks++;
    if (!found) begin errors++; $display("FAIL rx3_done: got no SEQ_DONE expected pulse"); end
    checks++;
    if ({SEQ_FAIL_MASK, SEQ_PASS, SEQ_PAT_IDX, SEQ_ERR_TOTAL} !== {9'h004, 1'b0, 8'd2, 32'd12}) begin
      errors++; $display("FAIL rx3_result: got mask/pass/idx/total %h expected %h",
        {SEQ_FAIL_MASK, SEQ_PASS, SEQ_PAT_IDX, SEQ_ERR_TOTAL}, {9'h004, 1'b0, 8'd2, 32'd12});
    end
    repeat (2) @(negedge clk);
    for (int i = wb; i < wq.size(); i++) if (wq[i].a == 8'h00) got_p.push_back(wq[i].d[7:0]);
    checks++;
    if (got_p.size() !== 3) begin
      errors++; $display("FAIL rx3_pattern_count: got %0d expected 3", got_p.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_p[i] !== exp_p[i]) begin
          errors++; $display("FAIL rx3_pattern%0d: got %h expected %h", i, got_p[i], exp_p[i]);
        end
      end
    end
  endtask

  task automatic test_rx5_errors;
    bit found;
    fault_ch = 5; hang = 1'b0;
    start_run(8'h00, 8'h00, 8'd1, 32'd10, 1'b0);
    wait_done(2000, found);
    checks++;
    if (!found) begin errors++; $display("FAIL rx5_done: got no SEQ_DONE expected pulse"); end
    checks++;
    if ({SEQ_ERR_TOTAL, SEQ_FAIL_MASK, SEQ_PASS} !== {32'd10, 9'h010, 1'b0}) begin
      errors++; $display("FAIL rx5_result: got total/mask/pass %h expected %h",
        {SEQ_ERR_TOTAL, SEQ_FAIL_MASK, SEQ_PASS}, {32'd10, 9'h010, 1'b0});
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout;
    int wb, c_go, c_stop, db;
    bit found;
    fault_ch = 0; hang = 1'b1;
    wb = wq.size(); db = done_cnt;
    start_run(8'h12, 8'h00, 8'd1, 32'd4, 1'b0);
    wait_done(2000, found);
    checks++;
    if (!found) begin errors++; $display("FAIL tmo_done: got no SEQ_DONE expected pulse"); end
    checks++;
    if ({SEQ_TIMEOUT, SEQ_FAIL_MASK, SEQ_PASS} !== {1'b1, 9'h1FF, 1'b0}) begin
      errors++; $display("FAIL tmo_result: got tmo/mask/pass %h expected %h",
        {SEQ_TIMEOUT, SEQ_FAIL_MASK, SEQ_PASS}, {1'b1, 9'h1FF, 1'b0});
    end
    repeat (3) @(negedge clk);
    c_go = -1; c_stop = -1;
    for (int i = wb; i < wq.size(); i++) begin
      if (wq[i].a == 8'h02 && wq[i].d == 32'd1 && c_go < 0) c_go = wq[i].c;
      if (wq[i].a == 8'h02 && wq[i].d == 32'd2 && c_stop < 0) c_stop = wq[i].c;
    end
    checks++;
    if (c_go < 0 || c_stop < 0 || (c_stop - c_go) < 95 || (c_stop - c_go) > 110) begin
      errors++; $display("FAIL tmo_stop_gap: got go=%0d stop=%0d expected stop 95..110 cycles after go", c_go, c_stop);
    end
    checks++;
    if (done_cnt - db !== 1) begin
      errors++; $display("FAIL tmo_done_count: got %0d expected 1", done_cnt - db);
    end
    hang = 1'b0;
  endtask

  task automatic test_reject;
    int wb, rb, jb;
    wb = wq.size(); rb = rq.size(); jb = reject_cnt;
    start_run(8'h01, 8'h01, 8'd1, 32'd0, 1'b0);
    checks++;
    if ({SEQ_REJECT, SEQ_BUSY} !== 2'b10) begin
      errors++; $display("FAIL reject_pulse: got reject/busy %b expected 10", {SEQ_REJECT, SEQ_BUSY});
    end
    repeat (10) @(negedge clk);
    checks++;
    if (wq.size() != wb || rq.size() != rb || SEQ_BUSY !== 1'b0 || reject_cnt - jb != 1) begin
      errors++; $display("FAIL reject_quiet: got %0d writes %0d reads busy=%b %0d pulses expected 0 0 0 1",
        wq.size() - wb, rq.size() - rb, SEQ_BUSY, reject_cnt - jb);
    end
  endtask

  task automatic test_abort_settle;
    int  rb, n_err;
    bit  hit;
    bit  found;
    fault_ch = 0; hang = 1'b0;
    start_run(8'h33, 8'h00, 8'd1, 32'd4, 1'b0);
    rb = rq.size();
    hit = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (M_RE && M_ADDR == 8'h03 && m_status[0]) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL abort_poll_seen: got no done poll expected one"); end
    repeat (2) @(negedge clk);
    SEQ_ABORT = 1'b1;
    @(negedge clk);
    SEQ_ABORT = 1'b0;
    checks++;
    if ({M_WE, M_ADDR, M_WDATA} !== {1'b1, 8'h02, 32'd2}) begin
      errors++; $display("FAIL abort_stop_write: got %h expected %h", {M_WE, M_ADDR, M_WDATA}, {1'b1, 8'h02, 32'd2});
    end
    @(negedge clk);
    checks++;
    if ({M_WE, M_ADDR, M_WDATA} !== {1'b1, 8'h02, 32'd4}) begin
      errors++; $display("FAIL abort_clr_write: got %h expected %h", {M_WE, M_ADDR, M_WDATA}, {1'b1, 8'h02, 32'd4});
    end
    wait_done(5, found);
    checks++;
    if (!found || SEQ_PASS !== 1'b0) begin
      errors++; $display("FAIL abort_done: got found=%b pass=%b expected found=1 pass=0", found, SEQ_PASS);
    end
    @(negedge clk);
    n_err = 0;
    for (int i = rb; i < rq.size(); i++) if (rq[i] >= 8'h0D) n_err++;
    checks++;
    if (n_err != 0) begin errors++; $display("FAIL abort_no_err_reads: got %0d expected 0", n_err); end
  endtask

  task automatic test_reset_mid_poll;
    int wb, rb;
    fault_ch = 0; hang = 1'b1;
    start_run(8'h01, 8'h00, 8'd1, 32'd4, 1'b0);
    repeat (30) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({M_ADDR, M_WDATA, M_WE, M_RE, SEQ_BUSY, SEQ_DONE, SEQ_PASS, SEQ_FAIL_MASK, SEQ_ERR_TOTAL,
         SEQ_PAT_IDX, SEQ_TIMEOUT, SEQ_REJECT} !== 96'd0) begin
      errors++; $display("FAIL reset_mid_poll: got %h expected 0", {M_ADDR, M_WDATA, M_WE, M_RE, SEQ_BUSY,
        SEQ_DONE, SEQ_PASS, SEQ_FAIL_MASK, SEQ_ERR_TOTAL, SEQ_PAT_IDX, SEQ_TIMEOUT, SEQ_REJECT});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hang = 1'b0;
    wb = wq.size(); rb = rq.size();
    repeat (20) @(negedge clk);
    checks++;
    if (wq.size() != wb || rq.size() != rb || SEQ_BUSY !== 1'b0) begin
      errors++; $display("FAIL reset_quiet: got %0d writes %0d reads busy=%b expected 0 0 0",
        wq.size() - wb, rq.size() - rb, SEQ_BUSY);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] got_p[$];
    int         wb;
    bit         found;
    fault_ch = 0; hang = 1'b0;
    wb = wq.size();
    start_run(8'h0F, 8'h01, 8'd2, 32'd4, 1'b1);
    repeat (3) @(negedge clk);
    SEQ_SEED = 8'hF0; SEQ_START = 1'b1;
    @(negedge clk);
    SEQ_START = 1'b0;
    wait_done(3000, found);
    checks++;
    if (!found || {SEQ_PASS, SEQ_PAT_IDX} !== {1'b1, 8'd1}) begin
      errors++; $display("FAIL b2b_result: got found=%b pass/idx %h expected found=1 %h", found,
        {SEQ_PASS, SEQ_PAT_IDX}, {1'b1, 8'd1});
    end
    repeat (2) @(negedge clk);
    for (int i = wb; i < wq.size(); i++) if (wq[i].a == 8'h00) got_p.push_back(wq[i].d[7:0]);
    checks++;
    if (got_p.size() !== 2 || got_p[0] !== 8'h0F || got_p[1] !== 8'h10) begin
      errors++; $display("FAIL b2b_patterns: got %0d patterns first=%h expected 2 patterns 0f,10",
        got_p.size(), (got_p.size() > 0) ? got_p[0] : 8'hxx);
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got no end of run expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    SEQ_START = 1'b0; SEQ_ABORT = 1'b0;
    SEQ_SEED = '0; SEQ_STEP = '0; SEQ_NUM_PAT = '0; SEQ_BYTES = '0;
    rst = 1'b1;
    test_reset();
    test_good();
    test_stuck_rx3();
    test_rx5_errors();
    test_timeout();
    test_reject();
    test_abort_settle();
    test_reset_mid_poll();
    test_back_to_back();
    checks++;
    if (both_seen !== 1'b0) begin
      errors++; $display("FAIL strobe_exclusive: got WE and RE together expected never");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
